subband_matrixer: RTL and testbench

- Parametrised successor to the single-channel subband collector in the MP3 decode path.
- Sits between the IMDCT/alias stage and the polyphase synthesis filterbank.
- Accepts one granule of frequency-inverted IMDCT samples per channel in subband-major order (sb outer, ss inner). Emits one NUM_SB-lane time-slot vector per (channel, ss) to synthesis under valid/ready.
- Ping-pong banks let granule N+1 be written while granule N is read out. Addresses are computed arithmetically; no index ROM.

---
 rtl/subband_matrixer.sv | 146 ++++++++++++++
 tb/tb_subband_matrixer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subband_matrixer.sv
// Ping-pong transpose buffer between the IMDCT/alias stage and the polyphase synthesis filterbank.
// Samples arrive subband-major; vectors leave as one NUM_SB-lane time slot per (channel, ss).
module subband_matrixer #(
    parameter int DATA_W = 32,
    parameter int NUM_SB = 32,
    parameter int NUM_SS = 18,
    parameter int NUM_CH = 2,
    localparam int GRAN = NUM_CH * NUM_SB * NUM_SS,
    localparam int AW = $clog2(2 * GRAN),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SS_W = $clog2(NUM_SS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     data_valid_in,
    output logic                     data_ready_out,
    output logic [NUM_SB*DATA_W-1:0] data_out,
    output logic                     data_valid_out,
    input  logic                     data_ready_in,
    output logic [CH_W-1:0]          ch_out,
    output logic [SS_W-1:0]          ss_out,
    output logic                     last_out
);
    localparam int LANE_W = $clog2(NUM_SB + 1);
    localparam int WC_W = $clog2(GRAN);

    // Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
    // a producer holds data and valid stable until that edge.
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state;
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [WC_W-1:0]   wr_count;
    logic [CH_W-1:0]   ch;
    logic [SS_W-1:0]   ss;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] mem [0:2*GRAN-1];
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    assign data_ready_out = rst_n && !full[wr_bank];
    assign wr_en = data_valid_in && data_ready_out && !flush;
    // lane counts one past the last issue so the final returned word can be captured
    assign rd_en = (state == FETCH) && (lane != LANE_W'(NUM_SB));
    assign wr_addr = (wr_bank ? AW'(GRAN) : AW'(0)) + AW'(wr_count);
    assign rd_addr = (rd_bank ? AW'(GRAN) : AW'(0)) + AW'(ch) * AW'(NUM_SB * NUM_SS)
                   + AW'(lane) * AW'(NUM_SS) + AW'(ss);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= data_in;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            full           <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_count       <= '0;
            ch             <= '0;
            ss             <= '0;
            lane           <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            ch_out         <= '0;
            ss_out         <= '0;
            last_out       <= 1'b0;
        end else if (flush) begin
            state          <= IDLE;
            full           <= '0;
            wr_bank        <= 1'b0;
            rd_bank        <= 1'b0;
            wr_count       <= '0;
            ch             <= '0;
            ss             <= '0;
            lane           <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            ch_out         <= '0;
            ss_out         <= '0;
            last_out       <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_count == WC_W'(GRAN - 1)) begin
                    wr_count      <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_count <= wr_count + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        ch    <= '0;
                        ss    <= '0;
                        lane  <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    for (int i = 0; i < NUM_SB; i++) begin
                        if (lane == LANE_W'(i + 1)) data_out[i*DATA_W +: DATA_W] <= rd_data;
                    end
                    if (lane == LANE_W'(NUM_SB)) begin
                        data_valid_out <= 1'b1;
                        ch_out         <= ch;
                        ss_out         <= ss;
                        last_out       <= (ch == CH_W'(NUM_CH - 1)) && (ss == SS_W'(NUM_SS - 1));
                        state          <= HOLD;
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                HOLD: begin
                    if (data_ready_in) begin
                        data_valid_out <= 1'b0;
                        if (last_out) begin
                            full[rd_bank] <= 1'b0;
                            rd_bank       <= ~rd_bank;
                            state         <= IDLE;
                        end else begin
                            lane  <= '0;
                            state <= FETCH;
                            if (ss == SS_W'(NUM_SS - 1)) begin
                                ss <= '0;
                                ch <= ch + 1'b1;
                            end else begin
                                ss <= ss + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_subband_matrixer.sv
// Directed bench for subband_matrixer: mono and stereo instances, scoreboard of expected
// vectors, a probe table of hand-computed lane values, and multi-cycle corner-case sequences.
module tb_subband_matrixer;
    localparam int DW = 32;
    localparam int NSB = 32;
    localparam int NSS = 18;
    localparam int LW = NSB * DW;
    localparam int VW = LW + 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stereo instance
    logic          flush = 1'b0;
    logic [DW-1:0] din = '0;
    logic          dvin = 1'b0;
    logic          rdy;
    logic [LW-1:0] dout;
    logic          dvout;
    logic          rdy_in = 1'b1;
    logic [0:0]    ch_o;
    logic [4:0]    ss_o;
    logic          last_o;
    // mono instance
    logic          m_flush = 1'b0;
    logic [DW-1:0] m_din = '0;
    logic          m_dvin = 1'b0;
    logic          m_rdy;
    logic [LW-1:0] m_dout;
    logic          m_dvout;
    logic          m_rdy_in = 1'b1;
    logic [0:0]    m_ch_o;
    logic [4:0]    m_ss_o;
    logic          m_last_o;

    subband_matrixer #(.DATA_W(DW), .NUM_SB(NSB), .NUM_SS(NSS), .NUM_CH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(din), .data_valid_in(dvin),
        .data_ready_out(rdy), .data_out(dout), .data_valid_out(dvout), .data_ready_in(rdy_in),
        .ch_out(ch_o), .ss_out(ss_o), .last_out(last_o));

    subband_matrixer #(.DATA_W(DW), .NUM_SB(NSB), .NUM_SS(NSS), .NUM_CH(1)) u_mono (
        .clk(clk), .rst_n(rst_n), .flush(m_flush), .data_in(m_din), .data_valid_in(m_dvin),
        .data_ready_out(m_rdy), .data_out(m_dout), .data_valid_out(m_dvout), .data_ready_in(m_rdy_in),
        .ch_out(m_ch_o), .ss_out(m_ss_o), .last_out(m_last_o));

    int total = 0;
    int bad = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] m_exp_q[$];
    logic          cap_en = 1'b0;
    logic [LW-1:0] cap [0:1][0:NSS-1];
    int            m_last_cyc = 0;

    typedef struct {
        int          ch;
        int          ss;
        int          sb;
        logic [31:0] val;
    } probe_t;
    probe_t probes[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk_vec(input int ch, input int ss, input int base, input int nch);
        logic [LW-1:0] d;
        logic lst;
        for (int sb = 0; sb < NSB; sb++) d[sb*DW +: DW] = DW'(base + ch * 1000 + sb * 18 + ss);
        lst = (ch == nch - 1) && (ss == NSS - 1);
        return {lst, 1'(ch), 5'(ss), d};
    endfunction

    task automatic cmp_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] e);
        int fl;
        total++;
        if (act !== e) begin
            bad++;
            fl = 0;
            for (int i = NSB - 1; i >= 0; i--) if (act[i*DW +: DW] !== e[i*DW +: DW]) fl = i;
            $display("FAIL %s act_tag=%0h exp_tag=%0h lane%0d act=%0d exp=%0d", name,
                     act[VW-1:LW], e[VW-1:LW], fl, act[fl*DW +: DW], e[fl*DW +: DW]);
        end
    endtask

    // stereo scoreboard: a handshake occurs at the next posedge when valid and ready are high here
    initial forever begin
        @(negedge clk);
        if (rst_n && dvout && rdy_in) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL vec_unexpected act_ch=%0d act_ss=%0d exp=none", ch_o, ss_o);
            end else begin
                cmp_vec("vec", {last_o, ch_o, ss_o, dout}, exp_q.pop_front());
            end
            if (cap_en) cap[ch_o][ss_o] = dout;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && m_dvout && m_rdy_in) begin
            if (m_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mono_unexpected act_ss=%0d exp=none", m_ss_o);
            end else begin
                cmp_vec("mono_vec", {m_last_o, m_ch_o, m_ss_o, m_dout}, m_exp_q.pop_front());
            end
            if (m_ss_o != 0) chk("mono_gap", 64'(cyc - m_last_cyc), 64'(NSB + 2));
            m_last_cyc = cyc;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_granule(input bit mono, input int base, input int nch);
        for (int c = 0; c < nch; c++)
            for (int s = 0; s < NSS; s++)
                if (mono) m_exp_q.push_back(mk_vec(c, s, base, nch));
                else exp_q.push_back(mk_vec(c, s, base, nch));
    endtask

    task automatic send_sample(input bit mono, input logic [31:0] v, inout int stalls);
        int n;
        n = 0;
        if (mono) begin m_din = v; m_dvin = 1'b1; end
        else begin din = v; dvin = 1'b1; end
        while (!(mono ? m_rdy : rdy) && n < 5000) begin
            tick();
            n++;
        end
        if (!(mono ? m_rdy : rdy)) chk("send_timeout", 64'(n), 64'(0));
        tick();
        stalls += n;
    endtask

    task automatic send_granule(input bit mono, input int base, input int nch, inout int stalls);
        for (int c = 0; c < nch; c++)
            for (int b = 0; b < NSB; b++)
                for (int s = 0; s < NSS; s++)
                    send_sample(mono, 32'(base + c * 1000 + b * 18 + s), stalls);
        if (mono) m_dvin = 1'b0;
        else dvin = 1'b0;
    endtask

    task automatic wait_drain(input bit mono, input int limit);
        int n;
        n = 0;
        while ((mono ? m_exp_q.size() : exp_q.size()) != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(mono ? "mono_drain" : "drain", 64'(mono ? m_exp_q.size() : exp_q.size()), 64'(0));
    endtask

    initial begin
        int stalls;
        int n;
        logic [LW-1:0] saved;
        probes[0] = '{0, 0, 0, 32'd0};
        probes[1] = '{0, 5, 0, 32'd5};
        probes[2] = '{0, 5, 31, 32'd563};
        probes[3] = '{0, 17, 31, 32'd575};
        probes[4] = '{0, 9, 16, 32'd297};
        probes[5] = '{1, 0, 0, 32'd1000};
        probes[6] = '{1, 3, 10, 32'd1183};
        probes[7] = '{1, 12, 7, 32'd1138};
        probes[8] = '{1, 17, 31, 32'd1575};

        // reset state
        tick(); tick(); tick();
        chk("rst_ready", 64'(rdy), 64'(0));
        chk("rst_valid", 64'(dvout), 64'(0));
        chk("rst_tags", 64'({last_o, ch_o, ss_o}), 64'(0));
        chk("rst_dout_zero", 64'(dout == '0), 64'(1));
        chk("rst_mono_ready", 64'(m_rdy), 64'(0));
        chk("rst_mono_valid", 64'(m_dvout), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(rdy), 64'(1));

        // mono granule, latency and throughput
        stalls = 0;
        push_granule(1'b1, 0, 1);
        send_granule(1'b1, 0, 1, stalls);
        n = 0;
        while (!m_dvout && n < 100) begin
            tick();
            n++;
        end
        chk("mono_latency", 64'(n), 64'(NSB + 2));
        wait_drain(1'b1, 1000);

        // stereo, two granules back-to-back through the ping-pong banks
        cap_en = 1'b1;
        stalls = 0;
        push_granule(1'b0, 0, 2);
        push_granule(1'b0, 0, 2);
        send_granule(1'b0, 0, 2, stalls);
        send_granule(1'b0, 0, 2, stalls);
        chk("pp_no_stall", 64'(stalls), 64'(0));
        wait_drain(1'b0, 4000);
        cap_en = 1'b0;
        for (int i = 0; i < 9; i++)
            chk($sformatf("probe_ch%0d_ss%0d_sb%0d", probes[i].ch, probes[i].ss, probes[i].sb),
                64'(cap[probes[i].ch][probes[i].ss][probes[i].sb*DW +: DW]), 64'(probes[i].val));

        // backpressure on vector ss=3
        stalls = 0;
        push_granule(1'b0, 90000, 2);
        send_granule(1'b0, 90000, 2, stalls);
        n = 0;
        while (!(dvout && ss_o == 5'd3 && ch_o == 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        chk("bp_found", 64'(dvout && ss_o == 5'd3), 64'(1));
        rdy_in = 1'b0;
        saved = dout;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 64'(dvout), 64'(1));
            chk("bp_ss", 64'(ss_o), 64'(3));
            chk("bp_data_stable", 64'(dout == saved), 64'(1));
        end
        rdy_in = 1'b1;
        wait_drain(1'b0, 3000);

        // both banks full
        rdy_in = 1'b0;
        stalls = 0;
        push_granule(1'b0, 10000, 2);
        push_granule(1'b0, 20000, 2);
        push_granule(1'b0, 30000, 2);
        send_granule(1'b0, 10000, 2, stalls);
        send_granule(1'b0, 20000, 2, stalls);
        chk("bb_no_stall", 64'(stalls), 64'(0));
        chk("bb_ready_low", 64'(rdy), 64'(0));
        repeat (5) tick();
        chk("bb_ready_still_low", 64'(rdy), 64'(0));
        fork
            send_granule(1'b0, 30000, 2, stalls);
            begin
                int w;
                w = 0;
                rdy_in = 1'b1;
                while (!(dvout && last_o) && w < 3000) begin
                    tick();
                    w++;
                end
                chk("bb_last_found", 64'(dvout && last_o), 64'(1));
                chk("bb_ready_before", 64'(rdy), 64'(0));
                tick();
                chk("bb_ready_after", 64'(rdy), 64'(1));
            end
        join
        wait_drain(1'b0, 6000);

        // reset partway through a granule
        for (int i = 0; i < 300; i++) send_sample(1'b0, 32'(50000 + i), stalls);
        dvin = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(rdy), 64'(0));
        chk("midrst_valid", 64'(dvout), 64'(0));
        chk("midrst_tags", 64'({last_o, ch_o, ss_o}), 64'(0));
        chk("midrst_dout_zero", 64'(dout == '0), 64'(1));
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_after", 64'(rdy), 64'(1));
        push_granule(1'b0, 60000, 2);
        send_granule(1'b0, 60000, 2, stalls);
        wait_drain(1'b0, 3000);

        // flush while holding vector 7
        for (int s = 0; s < 7; s++) exp_q.push_back(mk_vec(0, s, 70000, 2));
        send_granule(1'b0, 70000, 2, stalls);
        n = 0;
        while (!(dvout && ss_o == 5'd7 && ch_o == 1'b0) && n < 1000) begin
            tick();
            n++;
        end
        chk("fl_found", 64'(dvout && ss_o == 5'd7), 64'(1));
        rdy_in = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        chk("fl_valid", 64'(dvout), 64'(0));
        chk("fl_ready", 64'(rdy), 64'(1));
        chk("fl_tags", 64'({last_o, ch_o, ss_o}), 64'(0));
        chk("fl_dout_zero", 64'(dout == '0), 64'(1));
        chk("fl_queue", 64'(exp_q.size()), 64'(0));
        flush = 1'b0;
        rdy_in = 1'b1;
        push_granule(1'b0, 80000, 2);
        send_granule(1'b0, 80000, 2, stalls);
        wait_drain(1'b0, 3000);
        repeat (40) tick();
        chk("end_idle", 64'(dvout), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
